// File: rtl/movement_pkg.sv
// State codes shared by the sprite scheduler and its datapath, plus the
// helpers that decide which move state follows.
package movement_pkg;

  typedef enum logic [3:0] {
    ST_PREHOLD = 4'b0100,
    ST_HOLD    = 4'b0000,
    ST_CLEAR   = 4'b0001,
    ST_LEFT    = 4'b0011,
    ST_RIGHT   = 4'b0010,
    ST_DOWN    = 4'b0110,
    ST_UP      = 4'b0111,
    ST_DRAW    = 4'b0101
  } state_t;

  // Direction vectors are packed {up, down, right, left}.
  function automatic logic [3:0] cancel_opposed(input logic [3:0] dirs);
    return {dirs[3] & ~dirs[2], dirs[2] & ~dirs[3],
            dirs[1] & ~dirs[0], dirs[0] & ~dirs[1]};
  endfunction

  // Moves run in the order LEFT, RIGHT, DOWN, UP; DRAW follows the last one.
  function automatic state_t next_move(input state_t cur, input logic [3:0] en);
    logic [3:0] later;
    state_t     nxt;
    case (cur)
      ST_CLEAR: later = en;
      ST_LEFT:  later = en & 4'b1110;
      ST_RIGHT: later = en & 4'b1100;
      ST_DOWN:  later = en & 4'b1000;
      default:  later = 4'b0000;
    endcase
    if (later[0])      nxt = ST_LEFT;
    else if (later[1]) nxt = ST_RIGHT;
    else if (later[2]) nxt = ST_DOWN;
    else if (later[3]) nxt = ST_UP;
    else               nxt = ST_DRAW;
    return nxt;
  endfunction

endpackage

// File: rtl/done_watchdog.sv
// Down-counting watchdog for dp_done: expired rises in the TIMEOUT-th cycle
// after start if done has not been seen.
module done_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic done,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;

  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (start) begin
      cnt_d   = CW'(TIMEOUT - 1);
      armed_d = 1'b1;
    end else if (armed_q) begin
      if (done || cnt_q == '0) armed_d = 1'b0;
      else                     cnt_d   = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  assign expired = armed_q && (cnt_q == '0);

endmodule

// File: rtl/sprite_move_scheduler.sv
// Per-frame sequencer: clears, moves and redraws the player then the bird,
// issuing one datapath control code per state.
//
// state   | meaning
// PREHOLD | one cycle after reset
// HOLD    | idle, waiting for frame_tick or a pending tick
// CLEAR   | erase current sprite, wait for dp_done
// LEFT..UP| one-cycle move step for the current sprite
// DRAW    | redraw current sprite, wait for dp_done
module sprite_move_scheduler
  import movement_pkg::*;
#(
  parameter int BIRD_DIV     = 2,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       p_left,
  input  logic       p_right,
  input  logic       p_up,
  input  logic       p_down,
  input  logic       b_left,
  input  logic       b_right,
  input  logic       b_up,
  input  logic       b_down,
  input  logic       dp_done,
  output logic [3:0] control,
  output logic       porb,
  output logic       busy,
  output logic       frame_end,
  output logic       overrun,
  output logic       timeout_err
);

  state_t     state_q, state_d;
  logic       porb_q, porb_d, busy_q, busy_d, frame_end_q, frame_end_d;
  logic       overrun_q, overrun_d, timeout_err_q, timeout_err_d;
  logic       pending_q, pending_d;
  logic [3:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] dir_q, dir_d;
  logic [3:0] sel_dirs, move_en;
  logic       wd_start, wd_expired, wait_done;

  done_watchdog #(.TIMEOUT(DONE_TIMEOUT)) u_done_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (wd_start),
    .done    (dp_done),
    .expired (wd_expired)
  );

  always_comb begin
    // Bird moves are suppressed on frames that are not a BIRD_DIV multiple.
    sel_dirs      = porb_q ? ((frame_cnt_q == 4'd0) ? dir_q[7:4] : 4'b0000) : dir_q[3:0];
    move_en       = cancel_opposed(sel_dirs);
    wait_done     = dp_done | wd_expired;
    state_d       = state_q;
    porb_d        = porb_q;
    busy_d        = busy_q;
    frame_end_d   = 1'b0;
    overrun_d     = overrun_q;
    timeout_err_d = timeout_err_q;
    pending_d     = pending_q;
    frame_cnt_d   = frame_cnt_q;
    dir_d         = dir_q;
    case (state_q)
      ST_PREHOLD: state_d = ST_HOLD;
      ST_HOLD: begin
        if (frame_tick || pending_q) begin
          state_d = ST_CLEAR;
          porb_d  = 1'b0;
          busy_d  = 1'b1;
          dir_d   = {b_up, b_down, b_right, b_left, p_up, p_down, p_right, p_left};
        end
      end
      ST_CLEAR: begin
        if (wait_done) begin
          state_d = next_move(ST_CLEAR, move_en);
          if (!dp_done) timeout_err_d = 1'b1;
        end
      end
      ST_LEFT, ST_RIGHT, ST_DOWN, ST_UP: state_d = next_move(state_q, move_en);
      ST_DRAW: begin
        if (wait_done) begin
          if (!dp_done) timeout_err_d = 1'b1;
          if (!porb_q) begin
            state_d = ST_CLEAR;
            porb_d  = 1'b1;
          end else begin
            state_d     = ST_HOLD;
            busy_d      = 1'b0;
            frame_end_d = 1'b1;
            frame_cnt_d = (frame_cnt_q >= 4'(BIRD_DIV - 1)) ? 4'd0 : frame_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = ST_PREHOLD;
    endcase
    // A tick that cannot start a frame now is queued once; a second is lost.
    if (state_q == ST_HOLD) begin
      pending_d = pending_q & frame_tick;
    end else if (frame_tick) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end
    wd_start = (state_d == ST_CLEAR || state_d == ST_DRAW) && (state_d != state_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_PREHOLD;
      porb_q        <= 1'b0;
      busy_q        <= 1'b0;
      frame_end_q   <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      pending_q     <= 1'b0;
      frame_cnt_q   <= 4'd0;
      dir_q         <= 8'd0;
    end else begin
      state_q       <= state_d;
      porb_q        <= porb_d;
      busy_q        <= busy_d;
      frame_end_q   <= frame_end_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
      pending_q     <= pending_d;
      frame_cnt_q   <= frame_cnt_d;
      dir_q         <= dir_d;
    end
  end

  assign control     = state_q;
  assign porb        = porb_q;
  assign busy        = busy_q;
  assign frame_end   = frame_end_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sprite_move_scheduler.sv
// Bench for sprite_move_scheduler: a step-list model of each frame is
// compared against the DUT every cycle, with directed and random stimulus.
module tb_sprite_move_scheduler;

  localparam int BIRD_DIV     = 2;
  localparam int DONE_TIMEOUT = 64;

  localparam logic [3:0] C_PRE   = 4'b0100;
  localparam logic [3:0] C_HOLD  = 4'b0000;
  localparam logic [3:0] C_CLEAR = 4'b0001;
  localparam logic [3:0] C_LEFT  = 4'b0011;
  localparam logic [3:0] C_RIGHT = 4'b0010;
  localparam logic [3:0] C_DOWN  = 4'b0110;
  localparam logic [3:0] C_UP    = 4'b0111;
  localparam logic [3:0] C_DRAW  = 4'b0101;

  logic clk = 1'b0;
  logic reset_n, frame_tick, dp_done;
  logic p_left, p_right, p_up, p_down, b_left, b_right, b_up, b_down;
  logic [3:0] control;
  logic porb, busy, frame_end, overrun, timeout_err;

  sprite_move_scheduler #(.BIRD_DIV(BIRD_DIV), .DONE_TIMEOUT(DONE_TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .p_left(p_left), .p_right(p_right), .p_up(p_up), .p_down(p_down),
    .b_left(b_left), .b_right(b_right), .b_up(b_up), .b_down(b_down),
    .dp_done(dp_done), .control(control), .porb(porb), .busy(busy),
    .frame_end(frame_end), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] code;
    logic       pb;
    bit         w;
  } step_t;

  step_t q[$];
  bit    m_pre;
  logic  m_porb, m_fe, m_ovr, m_terr, m_pend;
  int    m_wait, m_frames;

  logic [4:0] tr[$];
  logic [4:0] last_obs;
  logic [4:0] exp_tr[$];
  int         fe_count;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic step_t mk(input logic [3:0] code, input logic pb, input bit w);
    step_t s;
    s.code = code;
    s.pb   = pb;
    s.w    = w;
    return s;
  endfunction

  // dirs packed {up, down, right, left}; opposing pairs cancel.
  function automatic void push_sprite(input logic [3:0] d, input logic pb);
    q.push_back(mk(C_CLEAR, pb, 1'b1));
    if (d[0] && !d[1]) q.push_back(mk(C_LEFT, pb, 1'b0));
    if (d[1] && !d[0]) q.push_back(mk(C_RIGHT, pb, 1'b0));
    if (d[2] && !d[3]) q.push_back(mk(C_DOWN, pb, 1'b0));
    if (d[3] && !d[2]) q.push_back(mk(C_UP, pb, 1'b0));
    q.push_back(mk(C_DRAW, pb, 1'b1));
  endfunction

  function automatic void model_reset();
    q.delete();
    m_pre = 1'b1; m_porb = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
    m_terr = 1'b0; m_pend = 1'b0; m_wait = 0; m_frames = 0;
  endfunction

  function automatic void model_step(input logic tick, input logic [3:0] pd,
                                     input logic [3:0] bd, input logic done);
    bit was_busy;
    bit advance;
    was_busy = (q.size() != 0);
    m_fe = 1'b0;
    if (was_busy) begin
      advance = 1'b1;
      if (q[0].w) begin
        m_wait++;
        if (!done) begin
          if (m_wait >= DONE_TIMEOUT) m_terr = 1'b1;
          else advance = 1'b0;
        end
      end
      if (advance) begin
        void'(q.pop_front());
        m_wait = 0;
        if (q.size() == 0) begin
          m_fe = 1'b1;
          m_frames++;
        end
      end
    end
    if (!was_busy && !m_pre && (tick || m_pend)) begin
      m_pend = m_pend && tick;
      push_sprite(pd, 1'b0);
      push_sprite(((m_frames % BIRD_DIV) == 0) ? bd : 4'b0000, 1'b1);
    end else if (tick) begin
      if (m_pend) m_ovr = 1'b1;
      else        m_pend = 1'b1;
    end
    m_pre = 1'b0;
    if (q.size() != 0) m_porb = q[0].pb;
  endfunction

  task automatic compare_all();
    logic [3:0] ec;
    ec = (q.size() != 0) ? q[0].code : (m_pre ? C_PRE : C_HOLD);
    check("control", control, ec);
    check("porb", porb, m_porb);
    check("busy", busy, q.size() != 0);
    check("frame_end", frame_end, m_fe);
    check("overrun", overrun, m_ovr);
    check("timeout_err", timeout_err, m_terr);
  endtask

  task automatic step(input logic tick, input logic [3:0] pd, input logic [3:0] bd,
                      input logic done);
    frame_tick = tick;
    {p_up, p_down, p_right, p_left} = pd;
    {b_up, b_down, b_right, b_left} = bd;
    dp_done = done;
    model_step(tick, pd, bd, done);
    @(posedge clk);
    #1;
    compare_all();
    if (frame_end === 1'b1) fe_count++;
    if ({porb, control} !== last_obs) begin
      tr.push_back({porb, control});
      last_obs = {porb, control};
    end
  endtask

  task automatic do_reset();
    frame_tick = 1'b0; dp_done = 1'b0;
    {p_up, p_down, p_right, p_left, b_up, b_down, b_right, b_left} = 8'h00;
    reset_n = 1'b0;
    #1;
    check("rst_control", control, C_PRE);
    check("rst_busy", busy, 1'b0);
    check("rst_porb", porb, 1'b0);
    check("rst_frame_end", frame_end, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tr.delete();
    last_obs = {porb, control};
    tr.push_back(last_obs);
  endtask

  task automatic check_trace(input string nm, input logic [4:0] e[$]);
    check({nm, "_len"}, tr.size(), e.size());
    for (int i = 0; i < e.size() && i < tr.size(); i++)
      check({nm, "_step"}, tr[i], e[i]);
  endtask

  task automatic finish_frame(input string nm);
    for (int i = 0; i < 400 && q.size() != 0; i++) step(1'b0, 4'h0, 4'h0, 1'b1);
    check({nm, "_bound"}, q.size(), 0);
  endtask

  task automatic run_frame(input string nm, input logic [3:0] pd, input logic [3:0] bd);
    tr.delete();
    fe_count = 0;
    step(1'b1, pd, bd, 1'b1);
    finish_frame(nm);
  endtask

  initial begin
    int n;
    int pct;
    reset_n = 1'b1;
    frame_tick = 1'b0; dp_done = 1'b0;
    {p_up, p_down, p_right, p_left, b_up, b_down, b_right, b_left} = 8'h00;
    #2;
    do_reset();

    // Empty frame from reset, including the PREHOLD/HOLD lead-in.
    fe_count = 0;
    step(1'b0, 4'h0, 4'h0, 1'b0);
    step(1'b1, 4'h0, 4'h0, 1'b1);
    finish_frame("empty");
    exp_tr = '{5'b00100, 5'b00000, 5'b00001, 5'b00101, 5'b10001, 5'b10101, 5'b10000};
    check_trace("empty_seq", exp_tr);
    check("empty_fe_pulses", fe_count, 1);

    // Frame count 1: opposed player moves cancel, bird moves suppressed.
    run_frame("cancel", 4'b0011, 4'b0100);
    exp_tr = '{5'b00001, 5'b00101, 5'b10001, 5'b10101, 5'b10000};
    check_trace("cancel_seq", exp_tr);

    // Frame count 0: player LEFT+UP, bird RIGHT.
    run_frame("moves", 4'b1001, 4'b0010);
    exp_tr = '{5'b00001, 5'b00011, 5'b00111, 5'b00101,
               5'b10001, 5'b10010, 5'b10101, 5'b10000};
    check_trace("moves_seq", exp_tr);

    // Three ticks while busy: one queued frame, overrun set.
    step(1'b1, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 4'h0, 4'h0, 1'b0);
    finish_frame("ovr_first");
    check("ovr_end_hold", control, C_HOLD);
    step(1'b0, 4'h0, 4'h0, 1'b1);
    check("ovr_restart_clear", control, C_CLEAR);
    check("ovr_restart_busy", busy, 1'b1);
    finish_frame("ovr_second");
    for (int i = 0; i < 5; i++) step(1'b0, 4'h0, 4'h0, 1'b1);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_idle", control, C_HOLD);

    // dp_done withheld in CLEAR: advance after exactly DONE_TIMEOUT cycles.
    do_reset();
    step(1'b0, 4'h0, 4'h0, 1'b0);
    step(1'b1, 4'h0, 4'h0, 1'b0);
    n = (control === C_CLEAR) ? 1 : 0;
    for (int i = 0; i < 200 && control === C_CLEAR; i++) begin
      step(1'b0, 4'h0, 4'h0, 1'b0);
      if (control === C_CLEAR) n++;
    end
    check("timeout_cycles", n, 64);
    check("timeout_state", control, C_DRAW);
    check("timeout_flag", timeout_err, 1'b1);
    finish_frame("timeout");

    // Reset in the middle of the bird DRAW: abandoned, no frame_end later.
    do_reset();
    step(1'b0, 4'h0, 4'h0, 1'b0);
    step(1'b1, 4'h0, 4'h0, 1'b1);
    for (int i = 0; i < 50 && !(q.size() != 0 && q[0].code == C_DRAW && q[0].pb); i++)
      step(1'b0, 4'h0, 4'h0, 1'b1);
    check("midreset_at_bird_draw", {porb, control}, {1'b1, C_DRAW});
    step(1'b0, 4'h0, 4'h0, 1'b0);
    do_reset();
    fe_count = 0;
    for (int i = 0; i < 10; i++) step(1'b0, 4'h0, 4'h0, 1'b1);
    check("midreset_no_fe", fe_count, 0);
    check("midreset_idle", control, C_HOLD);

    // Random traffic against the model.
    pct = 60;
    for (int i = 0; i < 5000; i++) begin
      if (i % 400 == 0) begin
        case ($urandom_range(0, 2))
          0: pct = 60;
          1: pct = 15;
          default: pct = 1;
        endcase
      end
      if (i == 1700 || i == 3900) do_reset();
      step(($urandom_range(0, 29) == 0), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), ($urandom_range(0, 99) < pct));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_move_scheduler.md
SPRITE_MOVE_SCHEDULER -- requirements
Module: sprite_move_scheduler

Interface
REQ-001 SHALL have parameter BIRD_DIV, default 2, meaning the bird moves once every BIRD_DIV frames (range 1..15).
REQ-002 SHALL have parameter DONE_TIMEOUT, default 64, meaning the maximum cycles to wait for dp_done in CLEAR or DRAW.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port frame_tick  input  1  one-cycle pulse starting a frame.
REQ-006 SHALL have port p_left, p_right, p_up, p_down  input  1 each  player crosshair direction requests.
REQ-007 SHALL have port b_left, b_right, b_up, b_down  input  1 each  bird direction requests.
REQ-008 SHALL have port dp_done  input  1  datapath sprite-draw-complete pulse.
REQ-009 SHALL have port control  output  4  datapath state code.
REQ-010 SHALL have port porb  output  1  sprite select: 0 = player, 1 = bird.
REQ-011 SHALL have port busy  output  1  high while a frame sequence is in progress.
REQ-012 SHALL have port frame_end  output  1  one-cycle pulse when a frame sequence completes.
REQ-013 SHALL have port overrun  output  1  sticky flag: a frame_tick was dropped.
REQ-014 SHALL have port timeout_err  output  1  sticky flag: dp_done did not arrive within DONE_TIMEOUT.

Function
REQ-015 SHALL use the state codes PREHOLD=0100, HOLD=0000, CLEAR=0001, LEFT=0011, RIGHT=0010, DOWN=0110, UP=0111, DRAW=0101, and drive control directly from the state register.
REQ-016 SHALL leave reset in PREHOLD for one cycle, then enter HOLD.
REQ-017 SHALL leave HOLD for CLEAR with porb=0 on frame_tick or on a pending tick, and clear the pending flag at that point.
REQ-018 SHALL sample all eight direction inputs into registers on the HOLD-to-CLEAR transition; inputs are ignored for the rest of the frame.
REQ-019 SHALL per sprite run CLEAR (wait for dp_done), then the LEFT/RIGHT/DOWN/UP states in that order, one cycle each and only for sampled requests, then DRAW (wait for dp_done).
REQ-020 SHALL skip both LEFT and RIGHT when both are requested, and skip both UP and DOWN when both are requested.
REQ-021 SHALL after the player DRAW completes, set porb=1 and repeat REQ-019 for the bird.
REQ-022 SHALL apply the bird's sampled moves only when the frame counter mod BIRD_DIV = 0; otherwise the bird runs CLEAR then DRAW.
REQ-023 SHALL count frames modulo BIRD_DIV with a 4-bit counter, incremented on each frame_end and wrapping to 0.
REQ-024 SHALL after the bird DRAW completes, return to HOLD, pulse frame_end for one cycle, and drop busy in the same cycle.
REQ-025 SHALL hold porb constant throughout each sprite's sequence, changing it only on the transitions in REQ-017 and REQ-021.
REQ-026 SHALL set pending on a frame_tick that arrives while busy; a tick arriving while pending is already set is dropped and sets overrun.
REQ-027 SHALL ignore dp_done outside CLEAR and DRAW.
REQ-028 SHALL count wait cycles in CLEAR and DRAW; if the count reaches DONE_TIMEOUT, it sets timeout_err and proceeds as if dp_done had arrived.
REQ-029 SHALL restart the wait counter at every entry into CLEAR or DRAW.

Reset
REQ-030 SHALL on reset_n low asynchronously set state=PREHOLD, control=0100, porb=0, busy=0, frame_end=0, overrun=0, timeout_err=0, pending=0, frame counter=0, wait counter=0, and all sampled directions=0.
REQ-031 SHALL abandon any in-progress frame on reset assertion mid-frame, and SHALL NOT resume it after release.

Structure
REQ-032 SHALL take the eight state codes from the shared package movement_pkg, which the datapath also uses.
REQ-033 SHALL implement the timeout as the sub-module done_watchdog (inputs: start, done; output: expired).

Verification
REQ-034 Reset, then frame_tick with no directions -> control sequence 0100, 0000, 0001(porb0), 0101(porb0), 0001(porb1), 0101(porb1), 0000 plus a frame_end pulse.
REQ-035 p_left=p_up=1 and b_right=1, frame count 0 -> player sequence CLEAR, LEFT, UP, DRAW; bird sequence CLEAR, RIGHT, DRAW.
REQ-036 p_left=p_right=1 -> player sequence CLEAR, DRAW with no LEFT or RIGHT; b_down=1 on frame count 1 with BIRD_DIV=2 -> no bird DOWN.
REQ-037 Three frame_ticks during one busy frame -> one extra frame runs immediately after, and overrun=1.
REQ-038 dp_done held low in CLEAR -> exactly 64 cycles later the state advances and timeout_err=1.
REQ-039 reset_n asserted mid-DRAW of the bird -> control=0100 and busy=0 immediately; no frame_end pulse after release.
